// File: rtl/ps2_rx_event_queue_pkg.sv
// ps2_rx_event_queue_pkg: PS/2 scan-code constants, frame size, FSM states and event record
package ps2_rx_event_queue_pkg;
   localparam logic [7:0] SCAN_EXTENDED  = 8'hE0;
   localparam logic [7:0] SCAN_KEY_UP    = 8'hF0;
   localparam int         PS2_FRAME_BITS = 11;
   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } evt_t;
endpackage

// File: rtl/ps2_rx_event_queue_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus FILTER_LEN-sample glitch filter, idles high
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic line_o
);
   localparam int CW = $clog2(FILTER_LEN);
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          filt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
         filt_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], line_i};
         if (sync_q[1] == filt_q) cnt_q <= '0;
         else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
         end else cnt_q <= cnt_q + 1'b1;
      end
   end
   assign line_o = filt_q;
endmodule

// File: rtl/ps2_rx_event_queue.sv
// ps2_rx_event_queue: PS/2 frame receiver, E0/F0 prefix decoder and FWFT key-event FIFO
module ps2_rx_event_queue
   import ps2_rx_event_queue_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int FIFO_DEPTH     = 8,
   parameter int CHECK_PARITY   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   output logic                        rx_byte_valid,
   output logic [7:0]                  rx_byte,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [7:0]                  evt_code,
   output logic                        evt_ext,
   output logic                        evt_release,
   output logic                        frame_err,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic          fclk, fdata, fclk_q, fall;
   state_t        st_q, st_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    sr_q, sr_d;
   logic [TW-1:0] to_q, to_d;
   logic [7:0]    rx_byte_q;
   logic          ext_q, rel_q, good, err, push, pop, full, wr_en;
   evt_t          mem [FIFO_DEPTH];
   evt_t          head;
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (.clk(clk), .rst(rst), .line_i(ps2_clk), .line_o(fclk));
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (.clk(clk), .rst(rst), .line_i(ps2_data), .line_o(fdata));

   assign fall = fclk_q & ~fclk;

   // sr_q shifts right so after bit 10 it holds {stop, parity, data[7:0]}
   always_comb begin
      st_d      = st_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      to_d      = '0;
      err       = 1'b0;
      good      = 1'b0;
      case (st_q)
         IDLE: if (fall) begin
            if (fdata) err = 1'b1;
            else begin
               st_d      = RECV;
               bit_cnt_d = 4'd1;
            end
         end
         RECV: if (fall) begin
            sr_d      = {fdata, sr_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            st_d      = (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) ? CHECK : RECV;
         end else begin
            to_d = to_q + 1'b1;
            if (to_d == TW'(TIMEOUT_CYCLES)) begin
               err  = 1'b1;
               st_d = IDLE;
            end
         end
         CHECK: begin
            err  = ~sr_q[9] | ((CHECK_PARITY != 0) & ~(^sr_q[8:0]));
            good = ~err;
            st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   assign push  = good & (sr_q[7:0] != SCAN_EXTENDED) & (sr_q[7:0] != SCAN_KEY_UP);
   assign evt_valid = cnt_q != '0;
   assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign pop   = evt_valid & evt_ready;
   assign wr_en = push & (~full | pop);
   assign head  = mem[rd_q];

   assign rx_byte_valid = good & ~rst;
   assign frame_err     = err & ~rst;
   assign overflow      = push & full & ~pop & ~rst;
   assign rx_byte       = good ? sr_q[7:0] : rx_byte_q;
   assign evt_code      = evt_valid ? head.code : 8'h00;
   assign evt_ext       = evt_valid & head.ext;
   assign evt_release   = evt_valid & head.rel;
   assign fifo_count    = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fclk_q    <= 1'b1;
         st_q      <= IDLE;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         to_q      <= '0;
         rx_byte_q <= '0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
      end else begin
         fclk_q    <= fclk;
         st_q      <= st_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         to_q      <= to_d;
         if (good) rx_byte_q <= sr_q[7:0];
         if (err) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
         end else if (good) begin
            ext_q <= (sr_q[7:0] == SCAN_EXTENDED) | (ext_q & ~push);
            rel_q <= (sr_q[7:0] == SCAN_KEY_UP) | (rel_q & ~push);
         end
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q] <= '{ext: ext_q, rel: rel_q, code: sr_q[7:0]};
   end
endmodule

// File: tb/tb_ps2_rx_event_queue.sv
// tb_ps2_rx_event_queue: scoreboard bench driving PS/2 frames and checking bytes, events and strobes
module tb_ps2_rx_event_queue;
   localparam int FL = 8, TO = 10000, FD = 8, H = 20;
   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, evt_ready = 1'b0;
   logic       rx_byte_valid, evt_valid, evt_ext, evt_release, frame_err, overflow;
   logic [7:0] rx_byte, evt_code;
   logic [3:0] fifo_count;
   int         checks = 0, failures = 0, cyc = 0, n_rx = 0, n_err = 0, n_ovf = 0, n_pop = 0;
   int         rx_cyc = 0, ev_cyc = 0;
   logic [7:0] last_rx = 8'h00;
   logic       ev_prev = 1'b0;
   logic [9:0] exp_q[$];

   ps2_rx_event_queue #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .CHECK_PARITY(1)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_code(evt_code), .evt_ext(evt_ext), .evt_release(evt_release), .frame_err(frame_err),
      .overflow(overflow), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin : monitor
      logic [9:0] e, got;
      cyc++;
      if (rx_byte_valid) begin
         n_rx++;
         last_rx = rx_byte;
         rx_cyc  = cyc;
      end
      if (frame_err) n_err++;
      if (overflow) n_ovf++;
      if (evt_valid && !ev_prev) ev_cyc = cyc;
      ev_prev = evt_valid;
      if (evt_valid && evt_ready) begin
         n_pop++;
         checks++;
         got = {evt_ext, evt_release, evt_code};
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL evt_unexpected got=%h required=none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL evt_pop got=%h required=%h", got, e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input logic [10:0] bits, input int n, input int glitch);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         if (i == glitch) begin
            tick(5);
            ps2_clk = 1'b0;
            tick(FL - 1);
            ps2_clk = 1'b1;
         end
         tick(H);
         ps2_clk = 1'b0;
         tick(H);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(H);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic flip, input int glitch);
      send_raw({1'b1, (~^c) ^ flip, c, 1'b0}, 11, glitch);
   endtask

   task automatic expect_evt(input logic ext, input logic rel, input logic [7:0] c);
      exp_q.push_back({ext, rel, c});
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((fifo_count != 0 || exp_q.size() != 0) && k < 500) begin
         tick(1);
         k++;
      end
      checks++;
      if (fifo_count !== 4'd0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain fifo_count=%0d pending=%0d required=0/0", name, fifo_count, exp_q.size());
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(4);
      checks++;
      if ({rx_byte_valid, rx_byte, evt_valid, evt_code, evt_ext, evt_release, frame_err, overflow, fifo_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b required=0", {rx_byte_valid, rx_byte, evt_valid, evt_code, evt_ext, evt_release, frame_err, overflow, fifo_count});
      end
      rst = 1'b0;
      tick(4);
      checks++;
      if (fifo_count !== 4'd0 || evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release fifo_count=%0d evt_valid=%b required=0/0", fifo_count, evt_valid);
      end
   endtask

   task automatic test_single;
      int rx0;
      rx0 = n_rx;
      evt_ready = 1'b0;
      expect_evt(1'b0, 1'b0, 8'h1C);
      send_frame(8'h1C, 1'b0, -1);
      checks++;
      if (n_rx - rx0 != 1 || last_rx !== 8'h1C) begin
         failures++;
         $display("FAIL single_rx strobes=%0d byte=%h required=1/1c", n_rx - rx0, last_rx);
      end
      checks++;
      if (ev_cyc - rx_cyc != 1) begin
         failures++;
         $display("FAIL single_latency got=%0d required=1", ev_cyc - rx_cyc);
      end
      checks++;
      if (fifo_count !== 4'd1 || {evt_ext, evt_release, evt_code} !== 10'h01C) begin
         failures++;
         $display("FAIL single_head count=%0d head=%h required=1/01c", fifo_count, {evt_ext, evt_release, evt_code});
      end
      evt_ready = 1'b1;
      wait_drain("single");
   endtask

   task automatic test_prefix;
      int p0, e0;
      p0 = n_pop;
      e0 = n_err;
      expect_evt(1'b0, 1'b1, 8'h1C);
      send_frame(8'hF0, 1'b0, -1);
      send_frame(8'h1C, 1'b0, -1);
      expect_evt(1'b1, 1'b1, 8'h75);
      send_frame(8'hE0, 1'b0, -1);
      send_frame(8'hF0, 1'b0, -1);
      send_frame(8'h75, 1'b0, -1);
      wait_drain("prefix");
      checks++;
      if (n_pop - p0 != 2 || n_err != e0) begin
         failures++;
         $display("FAIL prefix_counts events=%0d errs=%0d required=2/0", n_pop - p0, n_err - e0);
      end
   endtask

   task automatic test_parity_err;
      int e0, p0;
      e0 = n_err;
      p0 = n_pop;
      send_frame(8'hE0, 1'b0, -1);
      send_frame(8'h1C, 1'b1, -1);
      tick(20);
      checks++;
      if (n_err - e0 != 1 || n_pop != p0 || fifo_count !== 4'd0) begin
         failures++;
         $display("FAIL parity_err errs=%0d events=%0d count=%0d required=1/0/0", n_err - e0, n_pop - p0, fifo_count);
      end
      expect_evt(1'b0, 1'b0, 8'h1C);
      send_frame(8'h1C, 1'b0, -1);
      wait_drain("parity");
   endtask

   task automatic test_timeout;
      int e0;
      e0 = n_err;
      send_raw(11'b000_0010_1000, 5, -1);
      checks++;
      if (n_err != e0) begin
         failures++;
         $display("FAIL timeout_early errs=%0d required=0", n_err - e0);
      end
      tick(TO + 200);
      checks++;
      if (n_err - e0 != 1) begin
         failures++;
         $display("FAIL timeout_err errs=%0d required=1", n_err - e0);
      end
      expect_evt(1'b0, 1'b0, 8'h29);
      send_frame(8'h29, 1'b0, -1);
      wait_drain("timeout");
   endtask

   task automatic test_overflow;
      int o0, p0;
      evt_ready = 1'b0;
      o0 = n_ovf;
      for (int i = 0; i <= FD; i++) begin
         if (i < FD) expect_evt(1'b0, 1'b0, 8'h10 + 8'(i));
         send_frame(8'h10 + 8'(i), 1'b0, -1);
      end
      checks++;
      if (fifo_count !== 4'(FD) || n_ovf - o0 != 1) begin
         failures++;
         $display("FAIL overflow_fill count=%0d ovf=%0d required=%0d/1", fifo_count, n_ovf - o0, FD);
      end
      p0 = n_pop;
      expect_evt(1'b0, 1'b0, 8'h20);
      fork
         send_frame(8'h20, 1'b0, -1);
         begin
            int k;
            k = 0;
            do begin
               @(posedge clk);
               #1;
               k++;
            end while (!rx_byte_valid && k < 2000);
            checks++;
            if (!rx_byte_valid) begin
               failures++;
               $display("FAIL overflow_strobe_wait got=timeout required=rx_byte_valid");
            end
            evt_ready = 1'b1;
            @(posedge clk);
            #1;
            evt_ready = 1'b0;
         end
      join
      checks++;
      if (fifo_count !== 4'(FD) || n_ovf - o0 != 1 || n_pop - p0 != 1) begin
         failures++;
         $display("FAIL overflow_pushpop count=%0d ovf=%0d pops=%0d required=%0d/1/1", fifo_count, n_ovf - o0, n_pop - p0, FD);
      end
      evt_ready = 1'b1;
      wait_drain("overflow");
   endtask

   task automatic test_glitch;
      int r0;
      r0 = n_rx;
      expect_evt(1'b0, 1'b0, 8'h5A);
      send_frame(8'h5A, 1'b0, 4);
      checks++;
      if (n_rx - r0 != 1 || last_rx !== 8'h5A) begin
         failures++;
         $display("FAIL glitch_rx strobes=%0d byte=%h required=1/5a", n_rx - r0, last_rx);
      end
      wait_drain("glitch");
   endtask

   task automatic test_reset_mid;
      int e0;
      e0 = n_err;
      evt_ready = 1'b0;
      send_frame(8'h33, 1'b0, -1);
      checks++;
      if (fifo_count !== 4'd1) begin
         failures++;
         $display("FAIL rstmid_prefill count=%0d required=1", fifo_count);
      end
      send_raw({1'b1, 1'b1, 8'h55, 1'b0}, 4, -1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      checks++;
      if ({evt_valid, evt_code, fifo_count, frame_err, rx_byte_valid, overflow} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs got=%b required=0", {evt_valid, evt_code, fifo_count, frame_err, rx_byte_valid, overflow});
      end
      evt_ready = 1'b1;
      expect_evt(1'b0, 1'b0, 8'h44);
      send_frame(8'h44, 1'b0, -1);
      wait_drain("rstmid");
      checks++;
      if (n_err != e0 || last_rx !== 8'h44) begin
         failures++;
         $display("FAIL rstmid_after errs=%0d byte=%h required=0/44", n_err - e0, last_rx);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_prefix;
      test_parity_err;
      test_timeout;
      test_overflow;
      test_glitch;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ps2_rx_event_queue.md
Name: ps2_rx_event_queue

Overview:
Next-generation PS/2 keyboard receive path, fully in the system clock domain. Synchronises and glitch-filters ps2_clk/ps2_data and frames 11-bit packets with start/parity/stop checking and an inter-bit timeout. Decodes E0 (extended) and F0 (release) prefixes into single key events and buffers them in a parametrised FIFO with a valid/ready handshake. Sits between the PS/2 pins and any keyboard consumer.

Parameters:
FILTER_LEN, 8, consecutive identical samples needed before a filtered line changes state (>=2)
TIMEOUT_CYCLES, 10000, clk cycles allowed between falling ps2_clk edges within a frame before abort
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
CHECK_PARITY, 1, 1 = odd parity enforced; 0 = parity bit ignored

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ps2_clk  in  1  raw PS/2 clock line (asynchronous)
ps2_data  in  1  raw PS/2 data line (asynchronous)
rx_byte_valid  out  1  one-cycle strobe: a good frame was received
rx_byte  out  8  byte of last good frame
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head event
evt_code  out  8  scan code of head event
evt_ext  out  1  head event was E0-prefixed
evt_release  out  1  head event was F0-prefixed
frame_err  out  1  one-cycle strobe: bad start/parity/stop or timeout
overflow  out  1  one-cycle strobe: event dropped because FIFO full
fifo_count  out  clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; pending flags clear; sync/filter registers and filtered lines reset to 1 (bus idle).
- Each line: 2-FF synchroniser, then filter; filtered output toggles only after FILTER_LEN consecutive samples differing from it. Pulses shorter than FILTER_LEN cycles are ignored.
- Bit sample = filtered data on the cycle a filtered-clock 1->0 edge is detected (edge detect against previous filtered value).
- FSM IDLE: on edge, sampled bit 0 -> RECV with bit_cnt=1; sampled bit 1 -> frame_err, stay IDLE.
- FSM RECV: bits 1-8 data LSB first, bit 9 parity, bit 10 stop. On bit 10 -> CHECK for one cycle, then IDLE.
- CHECK: error if stop=0 or (CHECK_PARITY and ones(data,parity) even). Good -> rx_byte_valid=1, rx_byte=data. Bad -> frame_err=1.
- Latency: stop edge detected in cycle N -> rx_byte_valid/frame_err in N+1 -> event written end of N+1 -> evt_valid visible N+2 (FIFO previously empty).
- Timeout: in RECV, counter clears on every edge and increments otherwise; reaching TIMEOUT_CYCLES -> frame_err, IDLE, partial data discarded. Not counted in IDLE.
- Decoder on good byte: E0 -> set pending_ext; F0 -> set pending_rel; any other value -> push {pending_ext, pending_rel, byte}, clear both flags. E0/F0 never produce events. Any frame_err clears both flags.
- FIFO: first-word-fall-through; head drives evt_*. Pop when evt_valid & evt_ready. evt_code/evt_ext/evt_release hold stable while evt_valid & ~evt_ready.
- Full + push without pop: event dropped, overflow=1, contents unchanged. Full + push + pop same cycle: both occur, no overflow, count unchanged.
- Pointers wrap modulo FIFO_DEPTH; fifo_count = writes - reads, 0..FIFO_DEPTH.
- rst mid-frame or with FIFO non-empty: everything returns to reset state next cycle; partial frame and stored events lost; no strobes emitted.

Decomposition:
- ps2.vh gains SCAN_EXTENDED (8'hE0) alongside existing SCAN_KEY_UP (8'hF0), plus PS2_FRAME_BITS (11) and FSM state encodings (IDLE, RECV, CHECK).
- Sub-module ps2_line_filter (synchroniser + FILTER_LEN filter, parameter FILTER_LEN), instantiated twice. FIFO and decoder stay inline.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> rx_byte_valid once, rx_byte=1C; evt_valid at N+2 with {ext0,rel0,1C}; evt_ready=1 -> fifo_count 1->0.
- Frames F0 (parity 1), 1C -> exactly one event {0,1,1C}; E0, F0, 75 (parities 0,1,0) -> one event {1,1,75}.
- 0x1C with parity 1 after an E0 -> frame_err pulse, no event; next good 0x1C -> {0,0,1C} (pending_ext cleared).
- Stop after 5 edges, idle TIMEOUT_CYCLES -> single frame_err, FSM IDLE; following good 0x29 -> event 29.
- evt_ready=0, send FIFO_DEPTH+1 distinct codes -> fifo_count=FIFO_DEPTH, one overflow pulse; pops return first FIFO_DEPTH codes in order; full push+pop same cycle -> no overflow.
- ps2_clk low pulse of FILTER_LEN-1 cycles mid-frame -> no bit consumed, frame still decodes correctly; rst asserted mid-frame -> all outputs 0, next frame decodes normally.
